aes_key_schedule: RTL
=====================

// Module: aes_key_schedule
// PURPOSE
//  Iterative AES key expansion for AES-128/192/256, selected per job by key_len.
//  Expands a cipher key into Nr+1 128-bit round keys (11/13/15).
//  Computes one 32-bit schedule word per clock and streams each round key out
//  once it is complete. Sits between the key-load interface and the cipher round
//  datapath; the consumer stores the keys itself (no backpressure).
// PARAMETERS
//  KEY_MAX  256  width of key input, bits (largest supported key)
//  WORD_W   32   schedule word width
//  NB       4    words per round key (round key width = NB*WORD_W = 128)
//  IDX_W    4    round-key index width (covers 0..14)
// PORTS
//  clk       in   1        rising-edge clock
//  reset     in   1        synchronous, active-high
//  start     in   1        job request; sampled only when busy=0
//  key_len   in   2        00=128, 01=192, 10=256, 11=illegal
//  key       in   KEY_MAX  MSB-aligned key: w0=key[255:224]; unused LSBs ignored
//  busy      out  1        job in progress
//  rk_valid  out  1        one-cycle strobe: rk/rk_idx valid
//  rk        out  128      round key, word 4g in rk[127:96]
//  rk_idx    out  IDX_W    round number g of rk (0..Nr)
//  done      out  1        one-cycle strobe with the final rk_valid
//  err       out  1        one-cycle strobe: start with key_len=11 rejected
// BEHAVIOUR
//  Reset: busy, rk_valid, done, err = 0; rk, rk_idx = 0; FSM=IDLE; rcon=8'h01.
//  Nk = 4/6/8, Nr = 10/12/14, total words T = 4*(Nr+1) = 44/52/60.
//  FSM: IDLE -> LOAD (Nk cycles) -> EXPAND (T-Nk cycles) -> IDLE.
//  IDLE: start & legal key_len at edge E0 -> latch Nk/Nr and load key words into an
//   8-word window; busy=1 from E0. start & key_len=11 -> err=1 for one cycle,
//   stays IDLE.
//  Word stream: exactly one word is emitted per edge E1..ET.
//  LOAD: emit key words w0..w(Nk-1), oldest first.
//  EXPAND: w[i] = w[i-Nk] ^ temp, where i%Nk is tracked by a mod-Nk counter (no
//   divider) and temp is:
//   - i%Nk==0: SubWord(RotWord(w[i-1])) ^ {rcon,24'h0}, then rcon <= xtime(rcon);
//   - Nk==8 and i%Nk==4: SubWord(w[i-1]);
//   - otherwise: w[i-1].
//   Each new word shifts into the window and is emitted.
//  Assembler: packs emitted words 4 at a time. After edge E(4g+4): rk_valid=1,
//   rk={w4g..w4g+3}, rk_idx=g. Latency start->rk0 = 4 cycles; start->last = T cycles.
//  At the edge that emits w(T-1): rk_valid=1 with rk_idx=Nr, done=1, busy=0, FSM=IDLE,
//   rcon=01. start is accepted in that same cycle (back-to-back jobs, no bubble).
//  start while busy=1: ignored, inputs not re-latched. key/key_len may change freely
//   after E0.
//  rk and rk_idx hold their last value when rk_valid=0.
//  reset mid-job: abort at the next edge to the reset state; no done, no partial rk.
// STRUCTURE
//  aes_pkg: key_len_t enum (AES128/192/256), nk_of()/nr_of() functions, xtime()
//   function, sbox table/function shared with the cipher rounds.
//  Sub-module aes_sub_word: 4 parallel S-box lookups, 32b -> 32b, combinational.
//   One instance only, shared by the RotWord and plain SubWord cases.
// TESTING
//  1. AES-128 key 5468617473206D79204B756E67204675 -> rk_idx1 = E232FCF191129188B159E4E6D679A293;
//     rk_idx10 = 28FDDEF86DA4244ACCC0A4FE3B316F26; done 44 cycles after start; 11 strobes.
//  2. FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c -> rk_idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
//  3. FIPS-197 A.2 192-bit key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b ->
//     rk_idx12 = e98ba06f448c773c8ecc720401002202; 13 strobes; done at 52 cycles.
//  4. FIPS-197 A.3 256-bit key 603deb10...0914dff4 -> rk_idx14 = fe4890d1e6188d0b046df344706c631e;
//     done at 60 cycles.
//  5. key_len=11 -> err for 1 cycle, busy stays 0. start pulsed mid-job -> ignored, stream unchanged.
//     start in the done cycle -> second job's rk0 follows 4 cycles later.
//  6. reset at cycle 20 of a 256-bit job -> all outputs 0 next cycle; a new 128-bit job then
//     matches test 2 exactly (rcon restored).

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: key-length encoding, schedule sizing helpers, xtime and
// the forward S-box used by both the key schedule and the cipher rounds.
package aes_pkg;

    typedef enum logic [1:0] {
        AES128 = 2'b00,
        AES192 = 2'b01,
        AES256 = 2'b10
    } key_len_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [3:0] nk_of(input key_len_t kl);
        case (kl)
            AES192:  return 4'd6;
            AES256:  return 4'd8;
            default: return 4'd4;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input key_len_t kl);
        case (kl)
            AES192:  return 4'd12;
            AES256:  return 4'd14;
            default: return 4'd10;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: four parallel S-box lookups on a 32-bit word, purely combinational.
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] word,
    output logic [31:0] sub
);

    for (genvar b = 0; b < 4; b++) begin : g_byte
        assign sub[8*b +: 8] = sbox(word[8*b +: 8]);
    end

endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES-128/192/256 key expansion: one schedule word per clock, streamed
// out as 128-bit round keys as soon as each group of four words is complete.
module aes_key_schedule
    import aes_pkg::*;
#(
    parameter int KEY_MAX = 256,
    parameter int WORD_W  = 32,
    parameter int NB      = 4,
    parameter int IDX_W   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           key_len,
    input  logic [KEY_MAX-1:0]   key,
    output logic                 busy,
    output logic                 rk_valid,
    output logic [NB*WORD_W-1:0] rk,
    output logic [IDX_W-1:0]     rk_idx,
    output logic                 done,
    output logic                 err,
    output logic [1:0]           state_dbg
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_EXPAND = 2'd2;

    // Handshake: start is taken only on an edge where busy=0; busy rises from
    // that edge until the edge that emits the final word. There is no
    // backpressure, so rk_valid/done/err are single-cycle strobes.

    logic [1:0]        state;
    logic [3:0]        nk;
    logic [5:0]        last_idx;
    logic [2:0]        phase;
    logic [5:0]        cnt;
    logic [7:0]        rcon;
    logic [WORD_W-1:0] win [8];
    logic [WORD_W-1:0] acc [3];

    logic [3:0]        nk_new;
    logic [3:0]        nr_new;
    logic [WORD_W-1:0] key_words [8];
    logic [WORD_W-1:0] load_win [8];
    logic [2:0]        ld_sel;
    logic [2:0]        phase_next;
    logic [WORD_W-1:0] w_old;
    logic [WORD_W-1:0] w_prev;
    logic [WORD_W-1:0] sub_in;
    logic [WORD_W-1:0] sub_out;
    logic [WORD_W-1:0] temp;
    logic [WORD_W-1:0] exp_word;
    logic [WORD_W-1:0] emit_word;

    assign nk_new    = nk_of(key_len_t'(key_len));
    assign nr_new    = nr_of(key_len_t'(key_len));
    assign state_dbg = state;

    // Window holds the newest word in slot 0; the key is loaded so that after
    // LOAD finishes, slot Nk-1 is w[i-Nk] for the first expanded word.
    always_comb begin
        for (int j = 0; j < 8; j++) begin
            key_words[j] = key[KEY_MAX-1-WORD_W*j -: WORD_W];
        end
        for (int j = 0; j < 8; j++) begin
            load_win[j] = '0;
            if (j < int'(nk_new)) begin
                load_win[j] = key_words[3'(int'(nk_new) - 1 - j)];
            end
        end
    end

    assign ld_sel     = 3'(nk - 4'd1 - {1'b0, phase});
    assign phase_next = (phase == 3'(nk - 4'd1)) ? 3'd0 : phase + 3'd1;
    assign w_old      = win[3'(nk - 4'd1)];
    assign w_prev     = win[0];
    assign sub_in     = (phase == 3'd0) ? {w_prev[WORD_W-9:0], w_prev[WORD_W-1 -: 8]} : w_prev;

    aes_sub_word u_sub_word (
        .word (sub_in),
        .sub  (sub_out)
    );

    always_comb begin
        temp = w_prev;
        if (phase == 3'd0) begin
            temp = sub_out ^ {rcon, {(WORD_W-8){1'b0}}};
        end else if (nk == 4'd8 && phase == 3'd4) begin
            temp = sub_out;
        end
    end

    assign exp_word  = w_old ^ temp;
    assign emit_word = (state == ST_LOAD) ? win[ld_sel] : exp_word;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            rk_valid <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            rk       <= '0;
            rk_idx   <= '0;
            nk       <= 4'd4;
            last_idx <= '0;
            phase    <= '0;
            cnt      <= '0;
            rcon     <= 8'h01;
            for (int j = 0; j < 8; j++) win[j] <= '0;
            for (int j = 0; j < 3; j++) acc[j] <= '0;
        end else begin
            rk_valid <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (key_len == 2'b11) begin
                            err <= 1'b1;
                        end else begin
                            state    <= ST_LOAD;
                            busy     <= 1'b1;
                            nk       <= nk_new;
                            last_idx <= {nr_new, 2'b11};
                            phase    <= '0;
                            cnt      <= '0;
                            rcon     <= 8'h01;
                            for (int j = 0; j < 8; j++) win[j] <= load_win[j];
                        end
                    end
                end
                ST_LOAD, ST_EXPAND: begin
                    phase <= phase_next;
                    cnt   <= cnt + 6'd1;
                    if (state == ST_EXPAND) begin
                        for (int j = 7; j > 0; j--) win[j] <= win[j-1];
                        win[0] <= exp_word;
                        if (phase == 3'd0) rcon <= xtime(rcon);
                    end
                    if (state == ST_LOAD && phase == 3'(nk - 4'd1)) begin
                        state <= ST_EXPAND;
                    end
                    // Assembler: the fourth word of a group completes the round key.
                    case (cnt[1:0])
                        2'd0: acc[0] <= emit_word;
                        2'd1: acc[1] <= emit_word;
                        2'd2: acc[2] <= emit_word;
                        default: begin
                            rk       <= {acc[0], acc[1], acc[2], emit_word};
                            rk_idx   <= IDX_W'(cnt >> 2);
                            rk_valid <= 1'b1;
                        end
                    endcase
                    if (cnt == last_idx) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        rcon  <= 8'h01;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
